pipe_reg: RTL and testbench
===========================

PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data bits per stage, legal range 1..64.
REQ-002 SHALL provide parameter DEPTH, default 4: number of register stages, legal range 1..16.
REQ-003 SHALL provide port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port clear  input  1: reset, asynchronous, active-high.
REQ-005 SHALL provide port flush  input  1: synchronous discard of all stage contents.
REQ-006 SHALL provide port in_data  input  WIDTH: word offered upstream.
REQ-007 SHALL provide port in_valid  input  1: in_data holds a word.
REQ-008 SHALL provide port in_ready  output  1: pipe accepts a word this cycle.
REQ-009 SHALL provide port out_data  output  WIDTH: word in the last stage.
REQ-010 SHALL provide port out_valid  output  1: last stage holds a word.
REQ-011 SHALL provide port out_ready  input  1: downstream takes the word this cycle.
REQ-012 SHALL provide port count  output  clog2(DEPTH+1): number of occupied stages.

Function
REQ-013 SHALL hold DEPTH stages; each stage is a WIDTH-bit data register plus one valid bit.
REQ-014 SHALL count a transfer at the input when in_valid and in_ready are both 1 at a rising edge; the word then enters stage 0.
REQ-015 SHALL count a transfer at the output when out_valid and out_ready are both 1 at a rising edge; the last stage then empties or refills.
REQ-016 SHALL advance stage k into stage k+1 when stage k is valid and stage k+1 is empty or advancing in the same cycle; this makes the pipe elastic, with bubbles collapsing under back-pressure.
REQ-017 SHALL drive in_ready combinationally as: not flush, and (stage 0 empty or stage 0 advancing).
REQ-018 SHALL present a word at out_valid exactly DEPTH cycles after its input transfer when there is no back-pressure, and SHALL sustain one word per cycle.
REQ-019 SHALL keep a stalled stage's data and valid bit unchanged, preserving word order; no word may be duplicated or lost.
REQ-020 SHALL, on flush=1 at a rising edge, clear every valid bit to 0 and count to 0; an in_valid word in that cycle SHALL NOT be accepted; an output transfer in that cycle SHALL still complete.
REQ-021 SHALL update count each edge by: +1 on an input transfer only, -1 on an output transfer only, unchanged when both or neither occur.
REQ-022 SHALL, when full (count=DEPTH) and out_ready=1, accept a new word in the same cycle (count stays DEPTH).
REQ-023 SHALL, when full and out_ready=0, drive in_ready=0.
REQ-024 SHALL drive out_data from the last stage's data register regardless of out_valid; its value is don't-care when out_valid=0.
REQ-025 SHALL support DEPTH=1, where in_ready = not flush and (not out_valid or out_ready).

Reset
REQ-026 SHALL, while clear=1 (asynchronous, active-high), force all valid bits to 0, all data registers to 0, count to 0, and hence out_valid=0 and out_data=0.
REQ-027 SHALL discard words in flight when clear asserts mid-operation, and SHALL resume empty on the first rising edge after clear deasserts.
REQ-028 SHALL give clear priority over flush, and flush priority over load and shift.

Structure
REQ-029 SHALL place the WIDTH/DEPTH defaults and the count-width (ceil log2) function in a shared package pipe_pkg.
REQ-030 SHALL instantiate DEPTH copies of one sub-module pipe_stage, each holding one data register and one valid bit with load/hold/flush control; pipe_reg supplies the advance chain and count.

Verification
REQ-031 SHALL cover streaming: WIDTH=8, DEPTH=4, out_ready=1, inputs 0x01..0x08 on consecutive cycles -> 0x01 appears at out_valid 4 cycles later, then 0x02..0x08 one per cycle, count steady at 4.
REQ-032 SHALL cover back-pressure: fill with 0xA0..0xA3, out_ready=0 -> count=4 and in_ready=0; raise out_ready -> 0xA0..0xA3 drained in order, in_ready=1 on the first drain cycle.
REQ-033 SHALL cover full pass-through: full, out_ready=1, in_valid=1 with 0x55 -> in_ready=1, count stays 4, and 0x55 emerges after 0xA3.
REQ-034 SHALL cover flush: 3 words in flight, flush=1 with in_valid=1 (0x77) -> next cycle count=0 and out_valid=0, and 0x77 never emerges.
REQ-035 SHALL cover mid-run reset: clear pulsed asynchronously between edges with count=2 -> out_valid=0, out_data=0 and count=0 immediately; after release, 0x11 in -> 0x11 out 4 cycles later.
REQ-036 SHALL cover bubbles and DEPTH=1: in_valid toggling 1,0,1 with out_ready=0 -> words compact to count=2 with no loss; with DEPTH=1 -> the 0x01..0x08 streaming stimulus sustains one word per cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared defaults and sizing helper for the elastic register pipe.
package pipe_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  // Smallest r with 2**r >= value; used to size the occupancy counter.
  function automatic int clog2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipe slot: a data register plus its valid bit, with flush/load/drain control.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] data,
  output logic             vld
);

  // A load in the same cycle as a drain refills the slot, so load wins.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= ld_data;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Elastic DEPTH-stage register pipe with valid/ready handshake, flush and occupancy count.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             clear,
  input  logic                             flush,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [clog2_ceil(DEPTH+1)-1:0]   count
);

  localparam int CW = clog2_ceil(DEPTH + 1);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            load;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic                        free;
  logic                        in_xfer;
  logic                        out_xfer;

  // Walk from the output back: a slot may move on if the slot ahead is free
  // after this edge. The final value of free says whether stage 0 can take a word.
  always_comb begin
    adv  = '0;
    free = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = vld[k] && free;
      free   = !vld[k] || adv[k];
    end
  end

  assign in_ready  = !flush && free;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = adv[DEPTH-1];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] src;
    if (k == 0) begin : g_head
      assign load[k] = in_xfer;
      assign src     = in_data;
    end else begin : g_body
      assign load[k] = adv[k-1];
      assign src     = data[k-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .clear   (clear),
      .flush   (flush),
      .load    (load[k]),
      .drain   (adv[k]),
      .ld_data (src),
      .data    (data[k]),
      .vld     (vld[k])
    );
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: DEPTH=4 and DEPTH=1 instances share stimulus and are checked against a slot-position model.
module tb_pipe_reg;

  logic       clk = 1'b0;
  logic       clear;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       ir4, ov4, ir1, ov1;
  logic [7:0] od4, od1;
  logic [2:0] cnt4;
  logic [0:0] cnt1;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .clear(clear), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir4), .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .count(cnt4)
  );

  pipe_reg #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk(clk), .clear(clear), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .count(cnt1)
  );

  // Model: per instance, the words in flight (oldest first) and the stage each occupies.
  int         n [2] = '{0, 0};
  logic [7:0] md[2][17];
  int         mp[2][17];

  logic [7:0] log4[$];
  logic [7:0] log1[$];

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Where every remaining word sits after the coming edge, whether the oldest leaves,
  // and whether stage 0 will be free to take a new word.
  function automatic void plan(input int i, output int np[17], output bit lv, output bit rdy);
    int lim;
    int s;
    lv  = (n[i] > 0) && (mp[i][0] == dep(i) - 1) && (out_ready == 1'b1);
    lim = dep(i);
    s   = lv ? 1 : 0;
    for (int j = 0; j < 17; j++) np[j] = 0;
    for (int j = s; j < n[i]; j++) begin
      np[j] = (mp[i][j] + 1 < lim) ? mp[i][j] + 1 : mp[i][j];
      lim   = np[j];
    end
    rdy = (flush == 1'b0) && (lim > 0);
  endfunction

  function automatic void step(input int i);
    int np[17];
    bit lv;
    bit rdy;
    int m;
    plan(i, np, lv, rdy);
    if (flush) begin
      n[i] = 0;
    end else begin
      m = 0;
      for (int j = (lv ? 1 : 0); j < n[i]; j++) begin
        md[i][m] = md[i][j];
        mp[i][m] = np[j];
        m++;
      end
      if (in_valid && rdy) begin
        md[i][m] = in_data;
        mp[i][m] = 0;
        m++;
      end
      n[i] = m;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      n[0] = 0;
      n[1] = 0;
    end else begin
      step(0);
      step(1);
    end
  end

  always @(posedge clk) begin
    if (ov4 && out_ready) log4.push_back(od4);
    if (ov1 && out_ready) log1.push_back(od1);
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int   np[17];
    bit   lv;
    bit   rdy;
    bit   e_ov;
    logic a_ov, a_ir;
    logic [7:0] a_od;
    int   a_cnt;
    if (run_cmp && !clear) begin
      for (int i = 0; i < 2; i++) begin
        plan(i, np, lv, rdy);
        e_ov  = (n[i] > 0) && (mp[i][0] == dep(i) - 1);
        a_ov  = (i == 0) ? ov4 : ov1;
        a_ir  = (i == 0) ? ir4 : ir1;
        a_od  = (i == 0) ? od4 : od1;
        a_cnt = (i == 0) ? int'(cnt4) : int'(cnt1);
        chk($sformatf("d%0d_out_valid", dep(i)), 64'(a_ov), 64'(e_ov));
        if (e_ov) chk($sformatf("d%0d_out_data", dep(i)), 64'(a_od), 64'(md[i][0]));
        chk($sformatf("d%0d_count", dep(i)), 64'(a_cnt), 64'(n[i]));
        chk($sformatf("d%0d_in_ready", dep(i)), 64'(a_ir), 64'(rdy));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base4;
    int base1;
    clear = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ov4), 64'(0));
    chk("reset_out_data", 64'(od4), 64'(0));
    chk("reset_count", 64'(cnt4), 64'(0));
    chk("reset_d1_out_valid", 64'(ov1), 64'(0));
    #1 clear = 1'b0;
    run_cmp = 1'b1;

    // Streaming 0x01..0x08 with no back-pressure.
    out_ready = 1'b1;
    base4 = log4.size();
    base1 = log1.size();
    for (int t = 0; t < 8; t++) begin
      in_valid = 1'b1;
      in_data  = 8'(t + 1);
      #1 chk("d1_stream_ready", 64'(ir1), 64'(1));
      tick();
      chk("d1_stream_valid", 64'(ov1), 64'(1));
      chk("d1_stream_data", 64'(od1), 64'(t + 1));
      if (t + 1 == 3) chk("stream_latency_early", 64'(ov4), 64'(0));
      if (t + 1 >= 4) begin
        chk("stream_valid", 64'(ov4), 64'(1));
        chk("stream_data", 64'(od4), 64'(t - 2));
        chk("stream_count", 64'(cnt4), 64'(4));
      end
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("stream_out_words", 64'(log4.size() - base4), 64'(8));
    chk("d1_stream_out_words", 64'(log1.size() - base1), 64'(8));
    for (int k = 0; k < 8; k++) begin
      if (base4 + k < log4.size()) chk("stream_order", 64'(log4[base4 + k]), 64'(k + 1));
      if (base1 + k < log1.size()) chk("d1_stream_order", 64'(log1[base1 + k]), 64'(k + 1));
    end

    // Back-pressure fill, then pass-through while full.
    out_ready = 1'b0;
    base4 = log4.size();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + k);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("bp_count", 64'(cnt4), 64'(4));
    chk("bp_in_ready", 64'(ir4), 64'(0));
    chk("bp_head", 64'(od4), 64'(8'hA0));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    #1 chk("full_pass_in_ready", 64'(ir4), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("full_pass_count", 64'(cnt4), 64'(4));
    repeat (6) tick();
    chk("drain_words", 64'(log4.size() - base4), 64'(5));
    for (int k = 0; k < 5; k++) begin
      if (base4 + k < log4.size())
        chk("drain_order", 64'(log4[base4 + k]), (k == 4) ? 64'(8'h55) : 64'(8'hA0 + k));
    end

    // Flush with three words in flight and a word offered.
    out_ready = 1'b0;
    base4 = log4.size();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h31 + k);
      tick();
    end
    chk("pre_flush_count", 64'(cnt4), 64'(3));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    #1 chk("flush_in_ready", 64'(ir4), 64'(0));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", 64'(cnt4), 64'(0));
    chk("flush_out_valid", 64'(ov4), 64'(0));
    out_ready = 1'b1;
    repeat (6) tick();
    chk("flush_nothing_out", 64'(log4.size() - base4), 64'(0));

    // Asynchronous clear between edges with two words held.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h21 + k);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("pre_clear_count", 64'(cnt4), 64'(2));
    clear = 1'b1;
    #1;
    chk("clear_out_valid", 64'(ov4), 64'(0));
    chk("clear_out_data", 64'(od4), 64'(0));
    chk("clear_count", 64'(cnt4), 64'(0));
    clear = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("clear_resume_early", 64'(ov4), 64'(0));
    tick();
    chk("clear_resume_valid", 64'(ov4), 64'(1));
    chk("clear_resume_data", 64'(od4), 64'(8'h11));
    repeat (3) tick();

    // Bubbles collapse under back-pressure.
    out_ready = 1'b0;
    base4 = log4.size();
    in_valid = 1'b1; in_data = 8'h61; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h62; tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bubble_count", 64'(cnt4), 64'(2));
    chk("bubble_head", 64'(od4), 64'(8'h61));
    chk("bubble_in_ready", 64'(ir4), 64'(1));
    out_ready = 1'b1;
    repeat (3) tick();
    chk("bubble_words", 64'(log4.size() - base4), 64'(2));
    if (base4 + 1 < log4.size()) begin
      chk("bubble_first", 64'(log4[base4]), 64'(8'h61));
      chk("bubble_second", 64'(log4[base4 + 1]), 64'(8'h62));
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("final_count", 64'(cnt4), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
